// File: rtl/mic_set_framer.sv
// mic_set_framer
// Collects one sample from each of the four microphones (ids 0..3, in order)
// into a "set". Sets are written speculatively into a FIFO and committed only
// once complete, so a broken or out-of-order set is rolled back. Committed sets
// are streamed out as sign-extended 32-bit samples, with tlast on the final
// sample of every FRAME_SETS-set frame.
// Optional build macro: MIC_SET_FRAMER_STATS_EN adds drop_cnt and resync_cnt.
module mic_set_framer #(
   parameter int FIFO_AW    = 6,
   parameter int FRAME_SETS = 256
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] s_axis_tdata,
   input  logic [1:0]  s_axis_tuser,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic [1:0]  m_axis_tuser,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        overflow
`ifdef MIC_SET_FRAMER_STATS_EN
   ,
   output logic [15:0] drop_cnt,
   output logic [15:0] resync_cnt
`endif
);

   localparam int PW    = FIFO_AW + 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = 27;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      COL1 = 2'd1,
      COL2 = 2'd2,
      COL3 = 2'd3
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   cm_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   next_wr;
   logic [PW-1:0]   waddr;
   logic [EW-1:0]   wdata;
   logic [15:0]     set_cnt;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   out_entry;

   logic beat;
   logic full;
   logic we;
   logic commit;
   logic do_rollback;
   logic do_ovf;
   logic do_resync;
   logic unused_low_bits;

   // The low byte of each incoming word carries no audio
   assign unused_low_bits = ^s_axis_tdata[7:0];

   assign beat = s_axis_tvalid && s_axis_tready;
   assign full = (wr_ptr - rd_ptr) == PW'(DEPTH);

   // Only a mic-3 entry can close a set, so it alone may carry the frame marker
   assign wdata = {(s_axis_tuser == 2'd3) && (set_cnt == 16'(FRAME_SETS - 1)),
                   s_axis_tuser, s_axis_tdata[31:8]};

   // Decide what the current beat does to the set being assembled
   always_comb begin
      next_state  = state;
      next_wr     = wr_ptr;
      waddr       = wr_ptr;
      we          = 1'b0;
      commit      = 1'b0;
      do_rollback = 1'b0;
      do_ovf      = 1'b0;
      do_resync   = 1'b0;
      if (beat) begin
         if (full) begin
            do_rollback = 1'b1;
            do_ovf      = 1'b1;
            next_state  = HUNT;
            next_wr     = cm_ptr;
         end else if (state == HUNT) begin
            if (s_axis_tuser == 2'd0) begin
               we         = 1'b1;
               next_wr    = wr_ptr + PW'(1);
               next_state = COL1;
            end else begin
               do_resync = 1'b1;
            end
         end else if (s_axis_tuser == state) begin
            we      = 1'b1;
            next_wr = wr_ptr + PW'(1);
            case (state)
               COL1:    next_state = COL2;
               COL2:    next_state = COL3;
               default: begin
                  next_state = HUNT;
                  commit     = 1'b1;
               end
            endcase
         end else if (s_axis_tuser == 2'd0) begin
            do_rollback = 1'b1;
            do_resync   = 1'b1;
            we          = 1'b1;
            waddr       = cm_ptr;
            next_wr     = cm_ptr + PW'(1);
            next_state  = COL1;
         end else begin
            do_rollback = 1'b1;
            do_resync   = 1'b1;
            next_wr     = cm_ptr;
            next_state  = HUNT;
         end
      end
   end

   // Write-side state: set FSM, speculative/committed pointers, frame counter
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= HUNT;
         wr_ptr        <= '0;
         cm_ptr        <= '0;
         set_cnt       <= '0;
         overflow      <= 1'b0;
         s_axis_tready <= 1'b0;
      end else begin
         s_axis_tready <= 1'b1;
         state         <= next_state;
         wr_ptr        <= next_wr;
         if (commit) begin
            cm_ptr  <= wr_ptr + PW'(1);
            set_cnt <= (set_cnt == 16'(FRAME_SETS - 1)) ? 16'd0 : set_cnt + 16'd1;
         end
         if (do_ovf) begin
            overflow <= 1'b1;
         end
      end
   end

   // Sample storage; contents are meaningful only between rd_ptr and wr_ptr
   always_ff @(posedge aclk) begin
      if (we) begin
         mem[waddr[FIFO_AW-1:0]] <= wdata;
      end
   end

   // Output register refills whenever it is empty or being consumed
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rd_ptr        <= '0;
         out_entry     <= '0;
         m_axis_tvalid <= 1'b0;
      end else if (!m_axis_tvalid || m_axis_tready) begin
         if (rd_ptr != cm_ptr) begin
            out_entry     <= mem[rd_ptr[FIFO_AW-1:0]];
            rd_ptr        <= rd_ptr + PW'(1);
            m_axis_tvalid <= 1'b1;
         end else begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   assign m_axis_tdata = {{8{out_entry[23]}}, out_entry[23:0]};
   assign m_axis_tuser = out_entry[25:24];
   assign m_axis_tlast = out_entry[26];

`ifdef MIC_SET_FRAMER_STATS_EN
   // Saturating counters for overflow drops and stream resynchronisations
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         drop_cnt   <= '0;
         resync_cnt <= '0;
      end else begin
         if (do_ovf && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         if (do_resync && resync_cnt != 16'hFFFF) begin
            resync_cnt <= resync_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mic_set_framer.sv
// tb_mic_set_framer
// Directed bench for mic_set_framer with FIFO_AW=3 and FRAME_SETS=4.
module tb_mic_set_framer;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] s_axis_tdata;
   logic [1:0]  s_axis_tuser;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic [1:0]  m_axis_tuser;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        overflow;
`ifdef MIC_SET_FRAMER_STATS_EN
   logic [15:0] drop_cnt;
   logic [15:0] resync_cnt;
`endif

   int          vectors = 0;
   int          errors  = 0;
   logic        rand_ready = 1'b0;
   logic [63:0] obs_q [$];
   logic [63:0] exp_q [$];

   mic_set_framer #(.FIFO_AW(3), .FRAME_SETS(4)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .overflow      (overflow)
`ifdef MIC_SET_FRAMER_STATS_EN
      ,
      .drop_cnt      (drop_cnt),
      .resync_cnt    (resync_cnt)
`endif
   );

   // Free-running clock
   always #5 aclk = ~aclk;

   function automatic logic [63:0] pack(input logic l, input logic [1:0] u, input logic [31:0] d);
      return {29'd0, l, u, d};
   endfunction

   function automatic logic [31:0] sext(input logic [31:0] d);
      return {{8{d[31]}}, d[31:8]};
   endfunction

   // Record every completed output handshake, sampled mid-cycle
   always @(negedge aclk) begin
      if (!areset && m_axis_tvalid && m_axis_tready) begin
         obs_q.push_back(pack(m_axis_tlast, m_axis_tuser, m_axis_tdata));
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock; if the output was stalled going in, it must not have moved
   task automatic tick();
      logic        was_stall;
      logic [63:0] held;
      was_stall = m_axis_tvalid && !m_axis_tready && !areset;
      held      = pack(m_axis_tlast, m_axis_tuser, m_axis_tdata);
      @(posedge aclk);
      #1;
      if (was_stall) begin
         checkOutput("stall_hold", pack(m_axis_tlast, m_axis_tuser, m_axis_tdata), held);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] d, input logic [1:0] u);
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tvalid = 1'b1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain(input int cycles);
      repeat (cycles) begin
         if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   task automatic compareSet(input string tag, input int base);
      logic [63:0] o;
      checkOutput({tag, "_count"}, 64'(obs_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         o = (base + i < obs_q.size()) ? obs_q[base + i] : '1;
         checkOutput($sformatf("%s_beat%0d", tag, i), o, exp_q[i]);
      end
   endtask

   task automatic doReset();
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk);
      #1;
   endtask

   initial begin
      int          base;
      logic [31:0] d;

      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;

      // Reset values
      #2;
      checkOutput("rst_s_tready", 64'(s_axis_tready), 64'd0);
      checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      checkOutput("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      checkOutput("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
      checkOutput("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      checkOutput("post_rst_s_tready", 64'(s_axis_tready), 64'd1);

      // Clean stream: four sets, tlast on mic 3 of set 3
      $display("[TB] clean stream");
      m_axis_tready = 1'b1;
      base = obs_q.size();
      exp_q.delete();
      for (int s = 0; s < 4; s++) begin
         for (int m = 0; m < 4; m++) begin
            d = {(s[0] ? 8'hF0 : 8'h0F), 8'(s), 8'(m), 8'h5A};
            exp_q.push_back(pack(s == 3 && m == 3, 2'(m), sext(d)));
            applyStimulus(d, 2'(m));
         end
      end
      drain(10);
      compareSet("clean", base);
      checkOutput("clean_overflow", 64'(overflow), 64'd0);

      // Sign extension at the extremes
      $display("[TB] sign extension");
      base = obs_q.size();
      exp_q.delete();
      exp_q.push_back(pack(1'b0, 2'd0, 32'hFF80_0000));
      exp_q.push_back(pack(1'b0, 2'd1, 32'h007F_FFFF));
      exp_q.push_back(pack(1'b0, 2'd2, 32'h0000_0000));
      exp_q.push_back(pack(1'b0, 2'd3, 32'hFFFF_FFFF));
      applyStimulus(32'h8000_0000, 2'd0);
      applyStimulus(32'h7FFF_FF00, 2'd1);
      applyStimulus(32'h0000_00FF, 2'd2);
      applyStimulus(32'hFFFF_FFFF, 2'd3);
      drain(6);
      compareSet("sext", base);

      // Misordered ids: 0,1,3 is discarded, 0,1,2,3 survives
      $display("[TB] misorder");
      base = obs_q.size();
      exp_q.delete();
      exp_q.push_back(pack(1'b0, 2'd0, 32'h0001_0203));
      exp_q.push_back(pack(1'b0, 2'd1, 32'hFFF0_E0D0));
      exp_q.push_back(pack(1'b0, 2'd2, 32'h0012_3456));
      exp_q.push_back(pack(1'b0, 2'd3, 32'hFF87_6543));
      applyStimulus(32'hAAAA_AA00, 2'd0);
      applyStimulus(32'hBBBB_BB00, 2'd1);
      applyStimulus(32'hCCCC_CC00, 2'd3);
      applyStimulus(32'h0102_0300, 2'd0);
      applyStimulus(32'hF0E0_D000, 2'd1);
      applyStimulus(32'h1234_56FF, 2'd2);
      applyStimulus(32'h8765_4300, 2'd3);
      drain(6);
      compareSet("misorder", base);
`ifdef MIC_SET_FRAMER_STATS_EN
      checkOutput("misorder_resync", 64'(resync_cnt), 64'd1);
`endif

      // Backpressure: two sets fit, the third is dropped
      $display("[TB] overflow");
      doReset();
      m_axis_tready = 1'b0;
      base = obs_q.size();
      exp_q.delete();
      for (int s = 0; s < 3; s++) begin
         for (int m = 0; m < 4; m++) begin
            d = {8'(8'h30 + s), 8'(m), 8'hC3 ^ 8'(m), 8'h00};
            if (s < 2) exp_q.push_back(pack(1'b0, 2'(m), sext(d)));
            applyStimulus(d, 2'(m));
         end
      end
      drain(2);
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_head_valid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("ovf_head_data", 64'(m_axis_tdata), 64'h0000_0000_0030_00C3);
      m_axis_tready = 1'b1;
      drain(20);
      compareSet("ovf", base);
      checkOutput("ovf_drained_valid", 64'(m_axis_tvalid), 64'd0);

      // Reset in the middle of a set
      $display("[TB] reset mid-set");
      applyStimulus(32'h1111_1100, 2'd0);
      applyStimulus(32'h2222_2200, 2'd1);
      areset = 1'b1;
      #1;
      checkOutput("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      checkOutput("midrst_m_tdata", 64'(m_axis_tdata), 64'd0);
      checkOutput("midrst_overflow", 64'(overflow), 64'd0);
      checkOutput("midrst_s_tready", 64'(s_axis_tready), 64'd0);
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b0;
      base = obs_q.size();
      exp_q.delete();
      exp_q.push_back(pack(1'b0, 2'd0, 32'h0055_6677));
      exp_q.push_back(pack(1'b0, 2'd1, 32'hFF88_99AA));
      exp_q.push_back(pack(1'b0, 2'd2, 32'h0012_3412));
      exp_q.push_back(pack(1'b0, 2'd3, 32'hFFFE_DCBA));
      applyStimulus(32'h3333_3300, 2'd2);
      applyStimulus(32'h4444_4400, 2'd3);
      applyStimulus(32'h5566_7700, 2'd0);
      applyStimulus(32'h8899_AA00, 2'd1);
      applyStimulus(32'h1234_1200, 2'd2);
      applyStimulus(32'hFEDC_BA00, 2'd3);
      tick();
      checkOutput("commit_latency_valid", 64'(m_axis_tvalid), 64'd1);
      m_axis_tready = 1'b1;
      drain(10);
      compareSet("midrst", base);

      // Random backpressure while two sets flow through
      $display("[TB] random stall");
      rand_ready = 1'b1;
      base = obs_q.size();
      exp_q.delete();
      for (int s = 0; s < 2; s++) begin
         for (int m = 0; m < 4; m++) begin
            d = {8'(8'hA0 + 16 * s + m), 8'(m), 8'(s), 8'h00};
            exp_q.push_back(pack(1'b0, 2'(m), sext(d)));
            applyStimulus(d, 2'(m));
         end
      end
      drain(80);
      rand_ready    = 1'b0;
      m_axis_tready = 1'b1;
      drain(5);
      compareSet("stall", base);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mic_set_framer.md
Name: mic_set_framer

Overview:
- Sits directly downstream of i2s_if, consuming its 32-bit AXI-Stream microphone samples tagged by 2-bit mic id (tuser: 0=LEFT_LOW, 1=LEFT_HIGH, 2=RIGHT_LOW, 3=RIGHT_HIGH).
- Groups one sample from each of the four mics into an ordered "set" and discards incomplete or out-of-order sets.
- Buffers complete sets in a FIFO with speculative write and commit/rollback, and re-emits them as sign-extended 32-bit samples.
- Marks the end of every FRAME_SETS-set frame with tlast for the downstream DMA/beamformer.

Parameters:
- FIFO_AW, 6, FIFO address width; depth 2**FIFO_AW entries. Must be >=2 (depth >=4, one full set).
- FRAME_SETS, 256, sets per output frame; tlast period. Legal range 1..65535.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  32  sample from i2s_if; [31:8] signed 24-bit sample, [7:0] ignored.
- s_axis_tuser  in  2  mic id.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  tied to 1 after reset; the source is real-time and is never stalled.
- m_axis_tdata  out  32  sign-extended sample, equal to {{8{s[31]}}, s[31:8]}.
- m_axis_tuser  out  2  mic id (0..3, always in order).
- m_axis_tlast  out  1  last sample (mic 3) of the last set of a frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- overflow  out  1  sticky; a set was dropped because the FIFO was full. Cleared only by reset.

Behaviour:
- Reset (async, areset=1):
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, overflow=0.
  - All pointers=0, set counter=0, state=HUNT.
  - Assertion mid-set discards any uncommitted or buffered data.
  - After release, s_axis_tready=1 from the first clock edge.
- Pointers: rd_ptr, wr_ptr (speculative), cm_ptr (committed); all FIFO_AW+1 bits with a wrap bit.
  - Read side sees only cm_ptr.
  - Full when wr_ptr - rd_ptr == 2**FIFO_AW.
- Write FSM, states HUNT and COLLECT(exp), exp in 1..3. Per accepted beat (s_axis_tvalid=1):
  - HUNT, tuser==0, not full: write entry, wr_ptr++, go COLLECT(1).
  - HUNT, tuser!=0: drop the beat, stay in HUNT.
  - COLLECT(exp), tuser==exp, not full: write entry, wr_ptr++. If exp==3, commit (cm_ptr<=wr_ptr+1) and go HUNT; otherwise go COLLECT(exp+1).
  - COLLECT, tuser==0: rollback (wr_ptr<=cm_ptr), then treat the beat as HUNT with tuser==0 (restart set from this sample) in the same cycle.
  - COLLECT, other mismatch: rollback, go HUNT.
  - Full on any accepted beat (HUNT or COLLECT): rollback, overflow<=1, go HUNT. The beat is dropped even if tuser==0.
- FIFO entry: {tlast, tuser, sample[23:0]}.
  - tlast=1 only on the mic-3 entry when set_cnt==FRAME_SETS-1.
  - set_cnt increments on each commit and wraps FRAME_SETS-1 -> 0.
  - Rolled-back sets do not advance set_cnt.
- Read side: registered output stage with a first-word-fall-through look.
  - m_axis_tvalid rises no later than 2 cycles after the edge that committed a set into an empty FIFO.
  - Output holds stable while tvalid=1 and tready=0 (AXIS rule).
  - Full throughput of 1 beat/cycle is sustained while committed data exists.
- Simultaneous read and commit in one cycle: both take effect; the full check uses rd_ptr before that cycle's read.
- Output ordering is always complete sets 0,1,2,3; no partial set is ever emitted.

Optional Feature:
- Macro MIC_SET_FRAMER_STATS_EN adds two outputs:
  - drop_cnt [15:0]: counts sets dropped for overflow.
  - resync_cnt [15:0]: counts rollbacks caused by mic-id mismatch, plus HUNT beats dropped for tuser!=0.
  - Both are saturating at 16'hFFFF and reset to 0.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Clean stream: tuser 0,1,2,3 repeated with tready=1 and FRAME_SETS=4 -> output data equals input[31:8] sign-extended; tlast on every 16th beat (mic 3 of set 3); overflow=0.
- Sign extension: input 32'h8000_0000 -> output 32'hFF80_0000. Input 32'h7FFF_FF00 -> output 32'h007F_FFFF.
- Misorder: input tuser 0,1,3,0,1,2,3 -> only the last four samples appear, tuser 0..3; with STATS_EN, resync_cnt=1.
- Backpressure/overflow: FIFO_AW=3, tready=0, feed 3 full sets -> 2 sets buffered, third dropped, overflow=1. Then tready=1 -> exactly 8 beats out, in order.
- Reset mid-set: assert areset after tuser 0,1 -> outputs zero immediately. After release, feed 2,3,0,1,2,3 -> exactly one set out.
- Stall stability: random tready toggling -> tdata/tuser/tlast never change while tvalid=1 and tready=0.
